// File: rtl/register_bank.sv
// CPU register block: instruction register, program counter, general registers,
// ALU flags and a valid/ready output FIFO. Synchronous active-high reset.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SELW  = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       dbus,
  input  logic [WIDTH-1:0]       abus,
  input  logic                   load_ir,
  input  logic                   jump,
  input  logic                   pc_inc,
  input  logic                   reg_we,
  input  logic [SELW-1:0]        reg_sel,
  input  logic                   flag_we,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   out_push,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       ir,
  output logic [WIDTH-1:0]       pc,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic                   flag_carry,
  output logic                   flag_zero,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic                   out_full,
  output logic                   out_overflow
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;
  logic [31:0]      sel_ext;
  logic             pop;
  logic             push_ok;

  // ir, pc and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= '0;
      pc         <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else begin
      ir <= load_ir ? dbus : '0;
      if (jump)
        pc <= abus;
      else if (pc_inc)
        pc <= pc + WIDTH'(1);
      if (flag_we) begin
        flag_carry <= alu_carry;
        flag_zero  <= alu_zero;
      end
    end
  end

  // Out-of-range selects match no loop index, so they write nothing.
  assign sel_ext = 32'(reg_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        r[i] <= '0;
    end else if (reg_we) begin
      for (int unsigned i = 0; i < NREGS; i++)
        if (sel_ext == i)
          r[i] <= dbus;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      regs_flat[i*WIDTH +: WIDTH] = r[i];
  end

  // Output FIFO; a full FIFO still accepts a push when the head leaves on the same edge.
  assign out_valid = (count != '0);
  assign out_full  = (count == CNTW'(DEPTH));
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push_ok   = out_push && (!out_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= dbus;
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTRW'(1);
      if (push_ok && !pop)
        count <= count + CNTW'(1);
      else if (pop && !push_ok)
        count <= count - CNTW'(1);
      if (out_push && !push_ok)
        out_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed and random stimulus for register_bank, checked against a queue/array
// reference model; a second NREGS=3 instance covers the ignored-select case.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  dbus = '0, abus = '0;
  logic        load_ir = 0, jump = 0, pc_inc = 0, reg_we = 0;
  logic [1:0]  reg_sel = '0;
  logic        flag_we = 0, alu_carry = 0, alu_zero = 0, out_push = 0, out_ready = 0;

  logic [7:0]  ir, pc, out_data;
  logic [31:0] regs_flat;
  logic        flag_carry, flag_zero, out_valid, out_full, out_overflow;

  logic [7:0]  ir3, pc3, out_data3;
  logic [23:0] regs_flat3;
  logic        flag_carry3, flag_zero3, out_valid3, out_full3, out_overflow3;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_ir, m_pc;
  logic [7:0] m_r [4];
  logic [7:0] m_r3 [3];
  logic       m_c, m_z, m_ovf;
  logic [7:0] m_q [$];

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .NREGS(4), .SELW(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .dbus(dbus), .abus(abus), .load_ir(load_ir),
    .jump(jump), .pc_inc(pc_inc), .reg_we(reg_we), .reg_sel(reg_sel),
    .flag_we(flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_push(out_push), .out_ready(out_ready), .ir(ir), .pc(pc),
    .regs_flat(regs_flat), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .out_data(out_data), .out_valid(out_valid), .out_full(out_full),
    .out_overflow(out_overflow)
  );

  register_bank #(.WIDTH(8), .NREGS(3), .SELW(2), .DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .dbus(dbus), .abus(abus), .load_ir(load_ir),
    .jump(jump), .pc_inc(pc_inc), .reg_we(reg_we), .reg_sel(reg_sel),
    .flag_we(flag_we), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_push(out_push), .out_ready(out_ready), .ir(ir3), .pc(pc3),
    .regs_flat(regs_flat3), .flag_carry(flag_carry3), .flag_zero(flag_zero3),
    .out_data(out_data3), .out_valid(out_valid3), .out_full(out_full3),
    .out_overflow(out_overflow3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; load_ir = 0; jump = 0; pc_inc = 0; reg_we = 0; flag_we = 0;
    out_push = 0; out_ready = 0;
  endtask

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic step();
    bit pop, full;
    @(posedge clk);
    if (reset) begin
      m_ir = 0; m_pc = 0; m_c = 0; m_z = 0; m_ovf = 0;
      foreach (m_r[i]) m_r[i] = 0;
      foreach (m_r3[i]) m_r3[i] = 0;
      m_q.delete();
    end else begin
      m_ir = load_ir ? dbus : 8'h00;
      if (jump) m_pc = abus;
      else if (pc_inc) m_pc = 8'((int'(m_pc) + 1) % 256);
      if (reg_we) begin
        m_r[reg_sel] = dbus;
        if (reg_sel < 3) m_r3[reg_sel] = dbus;
      end
      if (flag_we) begin m_c = alu_carry; m_z = alu_zero; end
      full = (m_q.size() == 4);
      pop  = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (out_push) begin
        if (!full || pop) m_q.push_back(dbus);
        else m_ovf = 1;
      end
    end
    #1;
    chk("ir", ir, m_ir);
    chk("pc", pc, m_pc);
    chk("regs", regs_flat, {m_r[3], m_r[2], m_r[1], m_r[0]});
    chk("regs3", regs_flat3, {m_r3[2], m_r3[1], m_r3[0]});
    chk("carry", flag_carry, m_c);
    chk("zero", flag_zero, m_z);
    chk("valid", out_valid, m_q.size() > 0);
    chk("full", out_full, m_q.size() == 4);
    chk("ovf", out_overflow, m_ovf);
    if (m_q.size() > 0) chk("head", out_data, m_q[0]);
  endtask

  initial begin
    // reset
    reset = 1; step(); idle();
    chk("rst_pc", pc, 8'h00);
    chk("rst_data", out_data, 8'h00);

    // pc increment, jump, wrap
    pc_inc = 1;
    step(); chk("pc1", pc, 8'h01);
    step(); chk("pc2", pc, 8'h02);
    step(); chk("pc3", pc, 8'h03);
    pc_inc = 0; jump = 1; abus = 8'hF0; step(); chk("jmpF0", pc, 8'hF0);
    abus = 8'hFF; step();
    jump = 0; pc_inc = 1; step(); chk("wrap", pc, 8'h00);
    jump = 1; abus = 8'h40; step(); chk("jmp_prio", pc, 8'h40);
    idle(); load_ir = 1; dbus = 8'hA5; step(); chk("ir_ld", ir, 8'hA5);
    idle(); step(); chk("ir_nop", ir, 8'h00);

    // indexed register writes
    reg_we = 1;
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i); dbus = 8'(8'h11 * (i + 1)); step();
    end
    idle();
    chk("regs_all", regs_flat, 32'h44332211);
    chk("regs3_sel3", regs_flat3, 24'h332211);

    // FIFO fill, overflow, drain
    out_push = 1;
    for (int i = 1; i <= 5; i++) begin
      dbus = 8'(i); step();
      if (i == 4) chk("full4", out_full, 1'b1);
    end
    chk("ovf5", out_overflow, 1'b1);
    out_push = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain", out_data, 8'(i));
      step();
    end
    chk("drained", out_valid, 1'b0);

    // full FIFO with simultaneous push and pop
    idle(); reset = 1; step(); idle();
    out_push = 1;
    for (int i = 1; i <= 4; i++) begin dbus = 8'(i); step(); end
    dbus = 8'h09; out_ready = 1; step();
    chk("pp_full", out_full, 1'b1);
    chk("pp_ovf", out_overflow, 1'b0);
    out_push = 0;
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", out_data, (i == 3) ? 8'h09 : 8'(i + 2));
      step();
    end

    // flags
    idle(); flag_we = 1; alu_carry = 1; alu_zero = 0; step();
    chk("fc", flag_carry, 1'b1);
    chk("fz", flag_zero, 1'b0);
    flag_we = 0;
    for (int i = 0; i < 3; i++) begin alu_carry = ~alu_carry; alu_zero = ~alu_zero; step(); end
    chk("fc_hold", flag_carry, 1'b1);
    chk("fz_hold", flag_zero, 1'b0);

    // reset with traffic in the FIFO
    idle(); out_push = 1; dbus = 8'h5A; step(); step();
    reset = 1; out_ready = 1; load_ir = 1; step(); idle();
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_data", out_data, 8'h00);
    chk("mid_ir", ir, 8'h00);
    chk("mid_regs", regs_flat, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(63) == 0);
      dbus      = 8'($urandom);
      abus      = 8'($urandom);
      load_ir   = 1'($urandom);
      jump      = ($urandom_range(7) == 0);
      pc_inc    = 1'($urandom);
      reg_we    = 1'($urandom);
      reg_sel   = 2'($urandom);
      flag_we   = 1'($urandom);
      alu_carry = 1'($urandom);
      alu_zero  = 1'($urandom);
      out_push  = ($urandom_range(2) != 0);
      out_ready = ($urandom_range(2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the CPU register block: instruction register, program counter, N general registers, carry/zero flags, and a buffered output port.
- Sits between the control decoder, the data/address buses and the ALU. Every state change happens on the rising edge of clk.
- New over the previous generation: configurable width and register count, indexed register writes, a zero flag, and an output FIFO with a valid/ready handshake that replaces the single output latch.

Parameters:
- WIDTH, 8, datapath width for dbus, abus, pc, ir and the registers.
- NREGS, 4, number of general registers (1..16).
- SELW, 2, width of the register select field; must satisfy 2**SELW >= NREGS.
- DEPTH, 4, output FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- dbus  in  WIDTH  data bus
- abus  in  WIDTH  address bus (jump target)
- load_ir  in  1  capture dbus into ir
- jump  in  1  load pc from abus
- pc_inc  in  1  increment pc
- reg_we  in  1  register write enable
- reg_sel  in  SELW  register write index
- flag_we  in  1  update flags
- alu_carry  in  1  carry from ALU
- alu_zero  in  1  zero result from ALU
- out_push  in  1  enqueue dbus to the output FIFO
- out_ready  in  1  consumer accepts the head entry
- ir  out  WIDTH  instruction register
- pc  out  WIDTH  program counter
- regs_flat  out  NREGS*WIDTH  register r[i] at bits [i*WIDTH +: WIDTH]
- flag_carry  out  1  carry flag
- flag_zero  out  1  zero flag
- out_data  out  WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty
- out_full  out  1  FIFO full; the decoder stalls on this
- out_overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset, when reset=1 at a clk edge:
  - ir, pc, all registers, both flags, FIFO pointers, count and out_overflow clear to 0.
  - Consequently out_valid=0 and out_full=0.
  - Reset overrides every other input, including mid-stream FIFO traffic; queued data is discarded.
- ir:
  - Each edge: ir <= load_ir ? dbus : 0.
  - ir is a one-cycle capture that returns to 0 (NOP) unless reloaded.
- pc:
  - jump has priority: pc <= abus.
  - Otherwise, if pc_inc: pc <= pc+1, modulo 2**WIDTH (all-ones wraps to 0).
  - Otherwise pc holds.
- Registers:
  - If reg_we and reg_sel < NREGS: r[reg_sel] <= dbus.
  - reg_sel >= NREGS means the write is ignored, with no side effects.
  - Exactly one register changes per write.
- Flags:
  - If flag_we: flag_carry <= alu_carry and flag_zero <= alu_zero.
  - Otherwise both hold.
- Output FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (0..DEPTH).
  - out_data = mem[rd_ptr] whenever out_valid; when empty it is the stale entry, and consumers must ignore it.
  - Pop occurs when out_valid && out_ready.
  - Push is accepted when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - A push while full with no pop is dropped: out_overflow <= 1 and it stays set until reset.
  - Pushing into an empty FIFO gives out_valid=1 from the next cycle; there is no bypass path.
  - Push+pop on the same edge leaves count unchanged and advances both pointers.
  - Pointers wrap at DEPTH.
  - out_full = (count==DEPTH).
- All outputs are registered or derived from registered state; there is no combinational path from any input to any output.

Test Plan:
- Reset, then pc_inc=1 for 3 cycles, then jump with abus=8'hF0, then pc_inc with pc=8'hFF -> pc=1,2,3; then F0; then wraps to 00.
- jump=1 and pc_inc=1 together with abus=8'h40 -> pc=40, not an increment. load_ir with dbus=8'hA5 for 1 cycle -> ir=A5, then 00 the next cycle.
- reg_we with reg_sel=0..3 and dbus=11,22,33,44 -> regs_flat=44332211. With NREGS=3, SELW=2 and reg_sel=3 -> no register changes.
- Push 5 values (01..05) with out_ready=0, DEPTH=4:
  - out_full=1 after the 4th push.
  - 05 is dropped and out_overflow=1.
  - Raising out_ready drains 01,02,03,04 in order, then out_valid=0.
- With the FIFO full, push 09 and pop in the same cycle -> count stays 4, no overflow, and 09 is popped last.
- Flags:
  - flag_we with carry=1, zero=0 -> flags 1/0.
  - flag_we=0 while the ALU inputs toggle -> flags hold.
  - Assert reset mid-FIFO with 2 entries -> all outputs 0 and out_valid=0 next cycle.
